// File: rtl/kernel_convolve_if.sv
// kernel_convolve_if: kernel load, window and pixel handshakes for
// kernel_convolve. The master drives kernels and windows and accepts pixels.
interface kernel_convolve_if #(
  parameter int MAX_KERNEL = 3
);
  localparam int KW = $clog2(MAX_KERNEL + 1);

  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] kernel;
  logic [KW-1:0]                              kernel_size;
  logic                                       kernel_load;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] window;
  logic                                       window_valid;
  logic                                       window_ready;
  logic [7:0]                                 pixel_out;
  logic                                       pixel_valid;
  logic                                       pixel_ready;
  logic                                       busy;
  logic                                       err;

  modport master (
    output kernel, kernel_size, kernel_load, window, window_valid, pixel_ready,
    input  window_ready, pixel_out, pixel_valid, busy, err
  );

  modport slave (
    input  kernel, kernel_size, kernel_load, window, window_valid, pixel_ready,
    output window_ready, pixel_out, pixel_valid, busy, err
  );
endinterface

// File: rtl/kernel_convolve.sv
// kernel_convolve: latches a Q0.8 weight matrix on a load pulse, then filters
// one pixel window at a time with a single multiply-accumulate per cycle and
// emits a rounded 8-bit pixel.
// Optional feature: define KERNEL_CONVOLVE_SAT_EN to saturate results above
// 255 to 255; without it the rounded result wraps to its low 8 bits.
module kernel_convolve #(
  parameter int MAX_KERNEL = 3
) (
  input logic              clk,
  input logic              n_rst,
  kernel_convolve_if.slave bus
);

  localparam int KW = $clog2(MAX_KERNEL + 1);
  localparam int AW = 16 + $clog2(MAX_KERNEL * MAX_KERNEL);
  localparam int CW = (MAX_KERNEL > 1) ? $clog2(MAX_KERNEL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READY, S_MAC, S_OUT} state_t;

  state_t                                     r_state;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] r_kw;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] r_win;
  logic [KW-1:0]                              r_ks;
  logic [CW-1:0]                              r_cx;
  logic [CW-1:0]                              r_cy;
  logic [AW-1:0]                              r_acc;
  logic [7:0]                                 r_pixel_out;
  logic                                       r_pixel_valid;
  logic                                       r_window_ready;
  logic                                       r_busy;
  logic                                       r_err;

  logic          w_ks_ok;
  logic          w_load_bad;
  logic          w_win_hs;
  logic [15:0]   w_prod;
  logic [AW-1:0] w_acc_next;
  logic          w_cx_last;
  logic          w_last;

  // Round (+0.5 LSB of Q0.8) and narrow the accumulated sum to 8 bits.
  function automatic logic [7:0] f_round_sat(input logic [AW-1:0] acc);
`ifdef KERNEL_CONVOLVE_SAT_EN
    logic [AW-9:0] q;
    q = (AW-8)'((acc + AW'(128)) >> 8);
    return (q > (AW-8)'(255)) ? 8'hFF : q[7:0];
`else
    return 8'((acc + AW'(128)) >> 8);
`endif
  endfunction

  assign w_ks_ok    = (bus.kernel_size != '0) && (bus.kernel_size <= KW'(MAX_KERNEL));
  assign w_load_bad = bus.kernel_load && !w_ks_ok;
  // A rejected load in the same cycle blocks the window handshake.
  assign w_win_hs   = (r_state == S_READY) && bus.window_valid && !w_load_bad;
  assign w_prod     = 16'(r_kw[r_cy][r_cx]) * 16'(r_win[r_cy][r_cx]);
  // The accumulator cannot overflow: MAX_KERNEL^2*255*255+128 fits in AW bits.
  assign w_acc_next = r_acc + AW'(w_prod);
  assign w_cx_last  = (KW'(r_cx) == r_ks - KW'(1));
  assign w_last     = w_cx_last && (KW'(r_cy) == r_ks - KW'(1));

  assign bus.window_ready = r_window_ready;
  assign bus.pixel_out    = r_pixel_out;
  assign bus.pixel_valid  = r_pixel_valid;
  assign bus.busy         = r_busy;
  assign bus.err          = r_err;

  // Capture the pixel window on handshake; pure data, so no reset.
  always_ff @(posedge clk) begin
    if (w_win_hs) r_win <= bus.window;
  end

  // Control FSM: kernel storage, MAC sequencing and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= S_IDLE;
      r_kw           <= '0;
      r_ks           <= '0;
      r_cx           <= '0;
      r_cy           <= '0;
      r_acc          <= '0;
      r_pixel_out    <= '0;
      r_pixel_valid  <= 1'b0;
      r_window_ready <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.kernel_load) begin
            if (w_ks_ok) begin
              r_kw           <= bus.kernel;
              r_ks           <= bus.kernel_size;
              r_window_ready <= 1'b1;
              r_state        <= S_READY;
            end else begin
              r_kw  <= '0;
              r_ks  <= '0;
              r_err <= 1'b1;
            end
          end
        end

        S_READY: begin
          if (w_load_bad) begin
            r_kw           <= '0;
            r_ks           <= '0;
            r_err          <= 1'b1;
            r_window_ready <= 1'b0;
            r_state        <= S_IDLE;
          end else begin
            // A good load lands together with a coincident window.
            if (bus.kernel_load) begin
              r_kw <= bus.kernel;
              r_ks <= bus.kernel_size;
            end
            if (bus.window_valid) begin
              r_acc          <= '0;
              r_cx           <= '0;
              r_cy           <= '0;
              r_window_ready <= 1'b0;
              r_busy         <= 1'b1;
              r_state        <= S_MAC;
            end
          end
        end

        S_MAC: begin
          // Loads are refused here; the running sum keeps the old kernel.
          if (bus.kernel_load) r_err <= 1'b1;
          if (w_last) begin
            r_pixel_out   <= f_round_sat(w_acc_next);
            r_pixel_valid <= 1'b1;
            r_state       <= S_OUT;
          end else begin
            r_acc <= w_acc_next;
            if (w_cx_last) begin
              r_cx <= '0;
              r_cy <= r_cy + CW'(1);
            end else begin
              r_cx <= r_cx + CW'(1);
            end
          end
        end

        S_OUT: begin
          if (w_load_bad) begin
            // The pending pixel is dropped along with the kernel.
            r_kw          <= '0;
            r_ks          <= '0;
            r_err         <= 1'b1;
            r_pixel_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            if (bus.kernel_load) begin
              r_kw <= bus.kernel;
              r_ks <= bus.kernel_size;
            end
            if (bus.pixel_ready) begin
              r_pixel_valid  <= 1'b0;
              r_busy         <= 1'b0;
              r_window_ready <= 1'b1;
              r_state        <= S_READY;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
